// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if -- bundle between a value producer and the 7-segment
// scan driver.
//
//   value    producer -> driver  4*DIGITS nibbles, digit 0 in bits 3:0
//   load     producer -> driver  1-cycle strobe, capture value
//   lzb      producer -> driver  leading-zero blanking enable (level)
//   sg7      driver -> producer  {g,f,e,d,c,b,a}, active-low
//   an       driver -> producer  digit enables, active-low one-hot
//   frame    driver -> producer  pulse on scan wrap to digit 0
//   upd_pend driver -> producer  loaded value waiting for frame boundary
//
// master = producer side, slave = the driver.
interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic                load;
    logic                lzb;
    logic [6:0]          sg7;
    logic [DIGITS-1:0]   an;
    logic                frame;
    logic                upd_pend;

    modport master (
        output value, load, lzb,
        input  sg7, an, frame, upd_pend
    );

    modport slave (
        input  value, load, lzb,
        output sg7, an, frame, upd_pend
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver -- time-multiplexed driver for a DIGITS-wide common-anode
// 7-segment display. Each digit is held for CLK_DIV cycles in round-robin
// order. The displayed value is double-buffered and only swaps at a frame
// boundary (tick while the last digit is active) to avoid tearing.
//
// Parameters:
//   DIGITS   number of digits scanned (1..8)
//   CLK_DIV  clk cycles each digit stays active (>= 2)
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    seg7_scan_driver_if.slave (value/load/lzb in, sg7/an/frame/upd_pend out)
//
// Build option:
//   SEG7_HEX_EN  when defined, nibbles 10..15 decode as A,b,C,d,E,F;
//                otherwise they show "0" like the legacy BCD decoder.
module seg7_scan_driver #(
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    seg7_scan_driver_if.slave bus
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(CLK_DIV);
    localparam int VW = 4 * DIGITS;

    logic [CW-1:0]     cnt, cnt_next;
    logic [IW-1:0]     idx, idx_next;
    logic [VW-1:0]     pending, pending_next;
    logic [VW-1:0]     shadow, shadow_next;
    logic              pend, pend_next;
    logic              tick, boundary;
    logic [6:0]        sg7_q, sg7_next;
    logic [DIGITS-1:0] an_q, an_next;
    logic              frame_q;
    logic [DIGITS-1:0] zero_above;
    logic [3:0]        nib;
    logic              blank;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0011000;
`ifdef SEG7_HEX_EN
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
`else
            default: s = 7'b1000000;
`endif
        endcase
        return s;
    endfunction

    // Scan sequencing and double-buffer control.
    always_comb begin
        tick         = (cnt == CW'(CLK_DIV - 1));
        boundary     = tick && (idx == IW'(DIGITS - 1));
        cnt_next     = tick ? '0 : cnt + CW'(1);
        idx_next     = idx;
        if (tick) idx_next = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);

        shadow_next  = shadow;
        pending_next = pending;
        pend_next    = pend;
        if (boundary) begin
            // A load on the boundary edge bypasses the pending buffer.
            if (bus.load)  shadow_next = bus.value;
            else if (pend) shadow_next = pending;
            pend_next = 1'b0;
        end else if (bus.load) begin
            pending_next = bus.value;
            pend_next    = 1'b1;
        end
    end

    // zero_above[i]: nibbles i..DIGITS-1 of the value being displayed are zero.
    assign zero_above[DIGITS-1] = (shadow_next[VW-1 -: 4] == 4'h0);
    for (genvar i = 0; i < DIGITS - 1; i++) begin : g_zero
        assign zero_above[i] = (shadow_next[4*i +: 4] == 4'h0) && zero_above[i+1];
    end

    // Outputs are computed from the next-state values so that an and sg7
    // always change together and refer to the same digit.
    always_comb begin
        nib     = 4'h0;
        blank   = 1'b0;
        an_next = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_next == IW'(i)) begin
                nib        = shadow_next[4*i +: 4];
                blank      = bus.lzb && (i > 0) && zero_above[i];
                an_next[i] = 1'b0;
            end
        end
        sg7_next = blank ? 7'h7F : decode(nib);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx     <= '0;
            pending <= '0;
            pend    <= 1'b0;
            shadow  <= '0;
            sg7_q   <= 7'h7F;
            an_q    <= '1;
            frame_q <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            idx     <= idx_next;
            pending <= pending_next;
            pend    <= pend_next;
            shadow  <= shadow_next;
            sg7_q   <= sg7_next;
            an_q    <= an_next;
            frame_q <= boundary;
        end
    end

    assign bus.sg7      = sg7_q;
    assign bus.an       = an_q;
    assign bus.frame    = frame_q;
    assign bus.upd_pend = pend;
endmodule
